// File: rtl/ysyx_25030085_lsu.sv
// Load/store unit: turns one decoded core memory request into a single-beat bus
// transaction with byte strobes, then returns extended load data or an error.
module ysyx_25030085_lsu #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        lsu_valid,
  output logic        lsu_ready,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  mem_op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err,
  output logic        mreq_valid,
  input  logic        mreq_ready,
  output logic        mreq_we,
  output logic [31:0] mreq_addr,
  output logic [31:0] mreq_wdata,
  output logic [3:0]  mreq_wstrb,
  input  logic        mrsp_valid,
  input  logic [31:0] mrsp_rdata,
  input  logic        mrsp_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  function automatic logic req_illegal(input logic rd, input logic wr,
                                       input logic [2:0] op, input logic [1:0] off);
    logic bad_op;
    case (op)
      3'b000:  bad_op = 1'b0;
      3'b001:  bad_op = off[0];
      3'b010:  bad_op = (off != 2'b00);
      3'b100:  bad_op = wr;
      3'b101:  bad_op = wr | off[0];
      default: bad_op = 1'b1;
    endcase
    return (rd == wr) | bad_op;
  endfunction

  function automatic logic [31:0] store_lanes(input logic [1:0] sz, input logic [31:0] d);
    case (sz)
      2'b00:   store_lanes = {4{d[7:0]}};
      2'b01:   store_lanes = {2{d[15:0]}};
      default: store_lanes = d;
    endcase
  endfunction

  function automatic logic [3:0] store_strb(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      2'b00:   store_strb = 4'b0001 << off;
      2'b01:   store_strb = 4'b0011 << off;
      default: store_strb = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] op, input logic [1:0] off,
                                              input logic [31:0] word);
    logic [31:0] w;
    w = word >> {off, 3'b000};
    case (op)
      3'b000:  load_extend = {{24{w[7]}}, w[7:0]};
      3'b001:  load_extend = {{16{w[15]}}, w[15:0]};
      3'b010:  load_extend = w;
      3'b100:  load_extend = {24'h00_0000, w[7:0]};
      3'b101:  load_extend = {16'h0000, w[15:0]};
      default: load_extend = 32'h0000_0000;
    endcase
  endfunction

  state_t        state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic [2:0]    op_r, op_s;
  logic [1:0]    off_r, off_s;
  logic          done_r, done_s;
  logic          err_r, err_s;
  logic [31:0]   rdata_r, rdata_s;
  logic          mreq_valid_r, mreq_valid_s;
  logic          mreq_we_r, mreq_we_s;
  logic [31:0]   mreq_addr_r, mreq_addr_s;
  logic [31:0]   mreq_wdata_r, mreq_wdata_s;
  logic [3:0]    mreq_wstrb_r, mreq_wstrb_s;

  assign lsu_ready  = (state_r == IDLE);
  assign done       = done_r;
  assign err        = err_r;
  assign rdata      = rdata_r;
  assign mreq_valid = mreq_valid_r;
  assign mreq_we    = mreq_we_r;
  assign mreq_addr  = mreq_addr_r;
  assign mreq_wdata = mreq_wdata_r;
  assign mreq_wstrb = mreq_wstrb_r;

  // Next-state and next-output decode; timeout wins in REQ, a response wins in RSP.
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    op_s         = op_r;
    off_s        = off_r;
    done_s       = 1'b0;
    err_s        = err_r;
    rdata_s      = rdata_r;
    mreq_valid_s = 1'b0;
    mreq_we_s    = mreq_we_r;
    mreq_addr_s  = mreq_addr_r;
    mreq_wdata_s = mreq_wdata_r;
    mreq_wstrb_s = mreq_wstrb_r;
    case (state_r)
      IDLE: begin
        if (lsu_valid) begin
          op_s  = mem_op;
          off_s = addr[1:0];
          if (req_illegal(mem_read, mem_write, mem_op, addr[1:0])) begin
            state_s = DONE;
            done_s  = 1'b1;
            err_s   = 1'b1;
            rdata_s = 32'h0000_0000;
          end else begin
            state_s      = REQ;
            cnt_s        = {CW{1'b0}};
            mreq_valid_s = 1'b1;
            mreq_we_s    = mem_write;
            mreq_addr_s  = {addr[31:2], 2'b00};
            mreq_wdata_s = mem_write ? store_lanes(mem_op[1:0], wdata) : 32'h0000_0000;
            mreq_wstrb_s = mem_write ? store_strb(mem_op[1:0], addr[1:0]) : 4'b0000;
          end
        end else begin
          state_s = IDLE;
        end
      end
      REQ: begin
        cnt_s = cnt_r + 1'b1;
        if (cnt_r == CNT_LAST) begin
          state_s = DONE;
          done_s  = 1'b1;
          err_s   = 1'b1;
          rdata_s = 32'h0000_0000;
        end else if (mreq_ready) begin
          state_s = RSP;
        end else begin
          mreq_valid_s = 1'b1;
        end
      end
      RSP: begin
        cnt_s = cnt_r + 1'b1;
        if (mrsp_valid) begin
          state_s = DONE;
          done_s  = 1'b1;
          err_s   = mrsp_err;
          rdata_s = mreq_we_r ? 32'h0000_0000 : load_extend(op_r, off_r, mrsp_rdata);
        end else if (cnt_r == CNT_LAST) begin
          state_s = DONE;
          done_s  = 1'b1;
          err_s   = 1'b1;
          rdata_s = 32'h0000_0000;
        end else begin
          state_s = RSP;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State, timeout counter and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      cnt_r        <= {CW{1'b0}};
      op_r         <= 3'b000;
      off_r        <= 2'b00;
      done_r       <= 1'b0;
      err_r        <= 1'b0;
      rdata_r      <= 32'h0000_0000;
      mreq_valid_r <= 1'b0;
      mreq_we_r    <= 1'b0;
      mreq_addr_r  <= 32'h0000_0000;
      mreq_wdata_r <= 32'h0000_0000;
      mreq_wstrb_r <= 4'b0000;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      op_r         <= op_s;
      off_r        <= off_s;
      done_r       <= done_s;
      err_r        <= err_s;
      rdata_r      <= rdata_s;
      mreq_valid_r <= mreq_valid_s;
      mreq_we_r    <= mreq_we_s;
      mreq_addr_r  <= mreq_addr_s;
      mreq_wdata_r <= mreq_wdata_s;
      mreq_wstrb_r <= mreq_wstrb_s;
    end
  end

endmodule

// File: tb/tb_ysyx_25030085_lsu.sv
// Directed bench for the LSU: a spec-level transaction model checked every cycle,
// plus literal expectations from hand calculation.
module tb_ysyx_25030085_lsu;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        lsu_valid = 1'b0, lsu_ready;
  logic        mem_read = 1'b0, mem_write = 1'b0;
  logic [2:0]  mem_op = 3'b000;
  logic [31:0] addr = 32'h0, wdata = 32'h0;
  logic        done, err;
  logic [31:0] rdata;
  logic        mreq_valid, mreq_ready = 1'b0, mreq_we;
  logic [31:0] mreq_addr, mreq_wdata;
  logic [3:0]  mreq_wstrb;
  logic        mrsp_valid = 1'b0, mrsp_err = 1'b0;
  logic [31:0] mrsp_rdata = 32'h0;

  ysyx_25030085_lsu #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .lsu_valid(lsu_valid), .lsu_ready(lsu_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_op(mem_op), .addr(addr),
    .wdata(wdata), .done(done), .rdata(rdata), .err(err),
    .mreq_valid(mreq_valid), .mreq_ready(mreq_ready), .mreq_we(mreq_we),
    .mreq_addr(mreq_addr), .mreq_wdata(mreq_wdata), .mreq_wstrb(mreq_wstrb),
    .mrsp_valid(mrsp_valid), .mrsp_rdata(mrsp_rdata), .mrsp_err(mrsp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        legal;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic        err;
    int          done_cyc;
  } exp_t;

  int    checks = 0;
  int    errors = 0;
  bit    chk_en = 1'b0;
  bit    in_flight = 1'b0;
  exp_t  cur_e;
  exp_t  exp_q[$];
  logic [31:0] hold_rdata = 32'h0;
  logic        hold_err = 1'b0;
  longint      last_acc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // What a request must produce, from the access size/alignment rules and plain arithmetic.
  function automatic exp_t model(input logic rd, input logic we, input logic [2:0] op,
                                 input logic [31:0] a, input logic [31:0] wd,
                                 input logic [31:0] word, input logic berr,
                                 input int rdly, input bit withhold);
    exp_t e;
    int size, off;
    logic [31:0] v, mask;
    size = (op[1:0] == 2'd0) ? 1 : (op[1:0] == 2'd1) ? 2 : 4;
    off  = int'(a % 32'd4);
    e.legal = (rd != we) && !(op == 3'd3 || op == 3'd6 || op == 3'd7)
              && !(we && op >= 3'd4) && ((a % size) == 0);
    e.we    = we;
    e.addr  = a & 32'hFFFF_FFFC;
    e.wdata = !we ? 32'h0 : (size == 1) ? (wd & 32'hFF) * 32'h0101_0101
            : (size == 2) ? (wd & 32'hFFFF) * 32'h0001_0001 : wd;
    e.wstrb = we ? 4'(((1 << size) - 1) << off) : 4'b0000;
    if (!e.legal) begin
      e.err = 1'b1; e.rdata = 32'h0; e.done_cyc = 1;
    end else if (withhold || rdly + 2 > TO) begin
      e.err = 1'b1; e.rdata = 32'h0; e.done_cyc = TO + 1;
    end else begin
      e.err = berr; e.done_cyc = rdly + 3;
      if (we) begin
        e.rdata = 32'h0;
      end else begin
        mask = (size == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * size)) - 32'd1;
        v = (word >> (8 * off)) & mask;
        if (op < 3'd4 && size < 4 && v[8 * size - 1]) v = v | ~mask;
        e.rdata = v;
      end
    end
    return e;
  endfunction

  // Per-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("lsu_ready", {31'd0, lsu_ready}, {31'd0, !in_flight});
      if (in_flight && !cur_e.legal) chk("mreq_valid_on_illegal", {31'd0, mreq_valid}, 32'd0);
      if (mreq_valid) begin
        chk("mreq_addr", mreq_addr, cur_e.addr);
        chk("mreq_wdata", mreq_wdata, cur_e.wdata);
        chk("mreq_wstrb", {28'd0, mreq_wstrb}, {28'd0, cur_e.wstrb});
        chk("mreq_we", {31'd0, mreq_we}, {31'd0, cur_e.we});
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", {31'd0, done}, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("rdata", rdata, e.rdata);
          chk("err", {31'd0, err}, {31'd0, e.err});
          hold_rdata = e.rdata;
          hold_err   = e.err;
        end
        in_flight = 1'b0;
      end else begin
        chk("rdata_hold", rdata, hold_rdata);
        chk("err_hold", {31'd0, err}, {31'd0, hold_err});
      end
    end
  end

  int          t_dcyc, t_nvalid;
  logic [31:0] t_r, t_maddr, t_mwdata;
  logic        t_e;
  logic [3:0]  t_mwstrb;

  // One request plus a bus responder with rdly stall cycles on mreq_ready.
  task automatic do_txn(input logic rd, input logic we, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] word, input logic berr,
                        input int rdly, input bit withhold, input int abort_cyc);
    int n, stall;
    bit pending, got;
    exp_t e;
    t_dcyc = -1; t_nvalid = 0; t_r = 32'h0; t_e = 1'b0;
    t_maddr = 32'h0; t_mwdata = 32'h0; t_mwstrb = 4'h0;
    n = 0;
    @(negedge clk);
    while (!lsu_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", {31'd0, lsu_ready}, 32'd1);
    e = model(rd, we, op, a, wd, word, berr, rdly, withhold);
    cur_e = e;
    exp_q.push_back(e);
    lsu_valid = 1'b1; mem_read = rd; mem_write = we; mem_op = op; addr = a; wdata = wd;
    @(posedge clk);
    #1;
    last_acc  = $time;
    in_flight = 1'b1;
    lsu_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    stall = 0; pending = 1'b0; got = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (cyc == abort_cyc) begin
        mreq_ready = 1'b0; mrsp_valid = 1'b0;
        return;
      end
      if (done) begin
        got = 1'b1; t_dcyc = cyc; t_r = rdata; t_e = err;
        break;
      end
      if (mreq_valid) begin
        if (t_nvalid == 0) begin
          t_maddr = mreq_addr; t_mwdata = mreq_wdata; t_mwstrb = mreq_wstrb;
        end
        t_nvalid++;
      end
      mrsp_valid = pending && !withhold;
      mrsp_rdata = word;
      mrsp_err   = berr;
      if (mrsp_valid) pending = 1'b0;
      if (mreq_valid && stall >= rdly) begin
        mreq_ready = 1'b1;
        pending = 1'b1;
      end else begin
        mreq_ready = 1'b0;
        if (mreq_valid) stall++;
      end
    end
    mreq_ready = 1'b0; mrsp_valid = 1'b0;
    chk("done_seen", {31'd0, got}, 32'd1);
    chk("done_cycle", 32'(t_dcyc), 32'(e.done_cyc));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    longint t_lb;
    #3;
    chk("rst_ready", {31'd0, lsu_ready}, 32'd1);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_mreq_valid", {31'd0, mreq_valid}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // lw, immediate bus
    do_txn(1, 0, 3'b010, 32'h8000_0004, 32'h0, 32'hDEAD_BEEF, 0, 0, 0, 0);
    chk("lw_dcyc", 32'(t_dcyc), 32'd3);
    chk("lw_rdata", t_r, 32'hDEAD_BEEF);
    chk("lw_err", {31'd0, t_e}, 32'd0);
    chk("lw_maddr", t_maddr, 32'h8000_0004);
    chk("lw_wstrb", {28'd0, t_mwstrb}, 32'd0);
    // byte/halfword extension
    do_txn(1, 0, 3'b000, 32'h8000_0003, 32'h0, 32'h8011_2233, 0, 0, 0, 0);
    chk("lb_rdata", t_r, 32'hFFFF_FF80);
    t_lb = last_acc;
    do_txn(1, 0, 3'b100, 32'h8000_0003, 32'h0, 32'h8011_2233, 0, 0, 0, 0);
    chk("lbu_rdata", t_r, 32'h0000_0080);
    chk("b2b_spacing", 32'(last_acc - t_lb), 32'd40);
    do_txn(1, 0, 3'b101, 32'h8000_0002, 32'h0, 32'h8011_2233, 0, 0, 0, 0);
    chk("lhu_rdata", t_r, 32'h0000_8011);
    // sh with stalled mreq_ready
    do_txn(0, 1, 3'b001, 32'h8000_0006, 32'h1234_ABCD, 32'h0, 0, 3, 0, 0);
    chk("sh_wdata", t_mwdata, 32'hABCD_ABCD);
    chk("sh_wstrb", {28'd0, t_mwstrb}, 32'h0000_000C);
    chk("sh_dcyc", 32'(t_dcyc), 32'd6);
    chk("sh_nvalid", 32'(t_nvalid), 32'd4);
    // sb with bus error
    do_txn(0, 1, 3'b000, 32'h8000_0001, 32'h0000_0055, 32'h0, 1, 0, 0, 0);
    chk("sb_wdata", t_mwdata, 32'h5555_5555);
    chk("sb_wstrb", {28'd0, t_mwstrb}, 32'h0000_0002);
    chk("sb_berr", {31'd0, t_e}, 32'd1);
    do_txn(1, 0, 3'b001, 32'h8000_0002, 32'h0, 32'h7FFF_0000, 0, 1, 0, 0);
    do_txn(1, 0, 3'b001, 32'h8000_0000, 32'h0, 32'h1234_8001, 0, 2, 0, 0);
    chk("lh_neg", t_r, 32'hFFFF_8001);
    do_txn(0, 1, 3'b010, 32'h8000_0008, 32'hCAFE_F00D, 32'h0, 0, 1, 0, 0);
    // illegal requests: no bus activity, done at cycle 1
    do_txn(1, 0, 3'b010, 32'h8000_0002, 32'h0, 32'h0, 0, 0, 0, 0);
    chk("mis_lw_dcyc", 32'(t_dcyc), 32'd1);
    chk("mis_lw_err", {31'd0, t_e}, 32'd1);
    chk("mis_lw_nvalid", 32'(t_nvalid), 32'd0);
    do_txn(1, 1, 3'b010, 32'h8000_0000, 32'h0, 32'h0, 0, 0, 0, 0);
    chk("rdwr_err", {31'd0, t_e}, 32'd1);
    do_txn(1, 0, 3'b111, 32'h8000_0000, 32'h0, 32'h0, 0, 0, 0, 0);
    chk("op111_nvalid", 32'(t_nvalid), 32'd0);
    do_txn(0, 1, 3'b100, 32'h8000_0000, 32'h0, 32'h0, 0, 0, 0, 0);
    do_txn(1, 0, 3'b101, 32'h8000_0001, 32'h0, 32'h0, 0, 0, 0, 0);
    // timeouts: response withheld, then ready withheld too long
    do_txn(1, 0, 3'b010, 32'h8000_0010, 32'h0, 32'h1111_1111, 0, 0, 1, 0);
    chk("to_dcyc", 32'(t_dcyc), 32'd9);
    chk("to_err", {31'd0, t_e}, 32'd1);
    chk("to_rdata", t_r, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("late_rsp_done", {31'd0, done}, 32'd0);
      mrsp_valid = 1'b1; mrsp_rdata = 32'h2222_2222;
    end
    @(negedge clk);
    chk("late_rsp_done", {31'd0, done}, 32'd0);
    mrsp_valid = 1'b0;
    do_txn(0, 1, 3'b010, 32'h8000_0014, 32'h3333_3333, 32'h0, 0, 7, 0, 0);
    chk("to_req_dcyc", 32'(t_dcyc), 32'd9);
    do_txn(1, 0, 3'b010, 32'h8000_0010, 32'h0, 32'h0BAD_F00D, 0, 0, 0, 0);
    // reset while waiting for the response
    do_txn(0, 1, 3'b010, 32'h8000_000C, 32'h1357_9BDF, 32'h0, 0, 0, 1, 2);
    chk_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ready", {31'd0, lsu_ready}, 32'd1);
    chk("arst_done", {31'd0, done}, 32'd0);
    chk("arst_err", {31'd0, err}, 32'd0);
    chk("arst_rdata", rdata, 32'd0);
    chk("arst_mreq_valid", {31'd0, mreq_valid}, 32'd0);
    chk("arst_mreq_we", {31'd0, mreq_we}, 32'd0);
    chk("arst_mreq_addr", mreq_addr, 32'd0);
    chk("arst_mreq_wdata", mreq_wdata, 32'd0);
    chk("arst_mreq_wstrb", {28'd0, mreq_wstrb}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    in_flight = 1'b0; hold_rdata = 32'h0; hold_err = 1'b0;
    chk_en = 1'b1;
    do_txn(1, 0, 3'b010, 32'h8000_0000, 32'h0, 32'h00C0_FFEE, 0, 0, 0, 0);
    chk("post_rst_rdata", t_r, 32'h00C0_FFEE);
    chk("post_rst_dcyc", 32'(t_dcyc), 32'd3);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
